// File: rtl/tpu_layer_sequencer.sv
// Layer sequencer: steps NUM_LAYERS engines through clear/run phases in
// order, with a per-layer watchdog, abort, and registered status outputs.
module tpu_layer_sequencer #(
    parameter int          NUM_LAYERS     = 3,
    parameter logic [15:0] TIMEOUT_CYCLES = 16'd20000
) (
    input  logic                  clk,
    input  logic                  iRst_n,
    input  logic                  start,
    input  logic                  abort,
    input  logic [NUM_LAYERS-1:0] layer_done,
    input  logic [NUM_LAYERS-1:0] layer_overflow,
    output logic [NUM_LAYERS-1:0] layer_ena,
    output logic [NUM_LAYERS-1:0] layer_rst_n,
    output logic [1:0]            sel,
    output logic                  busy,
    output logic                  done,
    output logic                  overflow,
    output logic                  error
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_CLEAR,
        S_RUN,
        S_GAP,
        S_FIN,
        S_ERR
    } state_e;

    state_e                state_q, state_d;
    logic [1:0]            sel_q, sel_d;
    logic [15:0]           wdog_q, wdog_d;
    logic                  clr_q, clr_d;
    logic                  done_q, done_d;
    logic                  ovf_q, ovf_d;
    logic                  err_q, err_d;
    logic [NUM_LAYERS-1:0] ena_q, ena_d;
    logic [NUM_LAYERS-1:0] rstn_q, rstn_d;
    logic                  busy_q, busy_d;
    logic [NUM_LAYERS-1:0] sel_oh;
    logic [3:0]            done_pad;
    logic [3:0]            ovf_pad;
    logic                  last_layer;

    // Widen engine flags to the full sel range so indexing is always legal
    always_comb begin
        done_pad   = 4'(layer_done);
        ovf_pad    = 4'(layer_overflow);
        last_layer = (sel_q == 2'(NUM_LAYERS - 1));
    end

    // Next-state logic; abort overrides everything and keeps the flags
    always_comb begin
        state_d = state_q;
        sel_d   = sel_q;
        wdog_d  = wdog_q;
        clr_d   = clr_q;
        done_d  = done_q;
        ovf_d   = ovf_q;
        err_d   = err_q;
        if (abort) begin
            state_d = S_IDLE;
        end else begin
            unique case (state_q)
                S_IDLE, S_FIN, S_ERR: begin
                    if (start) begin
                        state_d = S_CLEAR;
                        sel_d   = '0;
                        clr_d   = 1'b0;
                        done_d  = 1'b0;
                        ovf_d   = 1'b0;
                        err_d   = 1'b0;
                    end
                end
                S_CLEAR: begin
                    if (clr_q) begin
                        state_d = S_RUN;
                        wdog_d  = '0;
                    end else begin
                        clr_d = 1'b1;
                    end
                end
                S_RUN: begin
                    if (done_pad[sel_q]) begin
                        ovf_d = ovf_q | ovf_pad[sel_q];
                        if (last_layer) begin
                            state_d = S_FIN;
                            done_d  = 1'b1;
                        end else begin
                            state_d = S_GAP;
                        end
                    end else if (wdog_q == TIMEOUT_CYCLES - 16'd1) begin
                        state_d = S_ERR;
                        err_d   = 1'b1;
                    end else begin
                        wdog_d = wdog_q + 16'd1;
                    end
                end
                S_GAP: begin
                    state_d = S_CLEAR;
                    sel_d   = sel_q + 2'd1;
                    clr_d   = 1'b0;
                end
                default: state_d = S_IDLE;
            endcase
        end
    end

    // Engine controls decoded from the next state so they can be registered
    always_comb begin
        for (int i = 0; i < NUM_LAYERS; i++) begin
            sel_oh[i] = (sel_d == 2'(i));
        end
        ena_d  = '0;
        rstn_d = '1;
        busy_d = 1'b0;
        unique case (state_d)
            S_CLEAR: begin
                ena_d  = sel_oh;
                rstn_d = ~sel_oh;
                busy_d = 1'b1;
            end
            S_RUN: begin
                ena_d  = sel_oh;
                busy_d = 1'b1;
            end
            S_GAP:   busy_d = 1'b1;
            default: busy_d = 1'b0;
        endcase
    end

    // State and output registers with asynchronous clear
    always_ff @(posedge clk or negedge iRst_n) begin
        if (!iRst_n) begin
            state_q <= S_IDLE;
            sel_q   <= '0;
            wdog_q  <= '0;
            clr_q   <= 1'b0;
            done_q  <= 1'b0;
            ovf_q   <= 1'b0;
            err_q   <= 1'b0;
            ena_q   <= '0;
            rstn_q  <= '1;
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            sel_q   <= sel_d;
            wdog_q  <= wdog_d;
            clr_q   <= clr_d;
            done_q  <= done_d;
            ovf_q   <= ovf_d;
            err_q   <= err_d;
            ena_q   <= ena_d;
            rstn_q  <= rstn_d;
            busy_q  <= busy_d;
        end
    end

    assign layer_ena   = ena_q;
    assign layer_rst_n = rstn_q;
    assign sel         = sel_q;
    assign busy        = busy_q;
    assign done        = done_q;
    assign overflow    = ovf_q;
    assign error       = err_q;

endmodule

// File: tb/tb_tpu_layer_sequencer.sv
// Testbench for tpu_layer_sequencer: vector table, directed corner
// sequences and random traffic against a phase-level model.
module tb_tpu_layer_sequencer;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       start;
    logic       abort;
    logic [2:0] ldone;
    logic [2:0] lovf;

    logic [2:0] ena_l, rstn_l, ena_s, rstn_s;
    logic [1:0] sel_l, sel_s;
    logic       busy_l, done_l, ovf_l, err_l;
    logic       busy_s, done_s, ovf_s, err_s;
    logic [11:0] act_l, act_s;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    tpu_layer_sequencer #(.NUM_LAYERS(3)) u_long (
        .clk(clk), .iRst_n(rst_n), .start(start), .abort(abort),
        .layer_done(ldone), .layer_overflow(lovf),
        .layer_ena(ena_l), .layer_rst_n(rstn_l), .sel(sel_l),
        .busy(busy_l), .done(done_l), .overflow(ovf_l), .error(err_l)
    );

    tpu_layer_sequencer #(.NUM_LAYERS(3), .TIMEOUT_CYCLES(16'd50)) u_short (
        .clk(clk), .iRst_n(rst_n), .start(start), .abort(abort),
        .layer_done(ldone), .layer_overflow(lovf),
        .layer_ena(ena_s), .layer_rst_n(rstn_s), .sel(sel_s),
        .busy(busy_s), .done(done_s), .overflow(ovf_s), .error(err_s)
    );

    assign act_l = {ena_l, rstn_l, sel_l, busy_l, done_l, ovf_l, err_l};
    assign act_s = {ena_s, rstn_s, sel_s, busy_s, done_s, ovf_s, err_s};

    // Phase-level model: which phase, which layer, cycles spent in phase
    localparam int P_IDLE = 0, P_CLR = 1, P_RUN = 2;
    localparam int P_GAP = 3, P_FIN = 4, P_ERR = 5;

    typedef struct {
        int ph;
        int lay;
        int cnt;
        bit dn;
        bit ov;
        bit er;
    } mdl_t;

    mdl_t m_l, m_s;

    function automatic mdl_t mreset();
        mdl_t n;
        n.ph = P_IDLE; n.lay = 0; n.cnt = 0;
        n.dn = 0; n.ov = 0; n.er = 0;
        return n;
    endfunction

    function automatic mdl_t mstep(mdl_t m, bit s, bit a,
                                   bit [2:0] d, bit [2:0] o, int tmo);
        mdl_t n = m;
        if (a) begin
            n.ph = P_IDLE;
            n.cnt = 0;
            return n;
        end
        case (m.ph)
            P_IDLE, P_FIN, P_ERR: if (s) begin
                n.ph = P_CLR; n.lay = 0; n.cnt = 0;
                n.dn = 0; n.ov = 0; n.er = 0;
            end
            P_CLR: begin
                n.cnt = m.cnt + 1;
                if (n.cnt == 2) begin
                    n.ph = P_RUN;
                    n.cnt = 0;
                end
            end
            P_RUN: begin
                n.cnt = m.cnt + 1;
                if (d[m.lay]) begin
                    n.ov = m.ov | o[m.lay];
                    if (m.lay == 2) begin
                        n.ph = P_FIN;
                        n.dn = 1;
                    end else begin
                        n.ph = P_GAP;
                    end
                end else if (n.cnt == tmo) begin
                    n.ph = P_ERR;
                    n.er = 1;
                end
            end
            P_GAP: begin
                n.lay = m.lay + 1;
                n.ph = P_CLR;
                n.cnt = 0;
            end
            default: ;
        endcase
        return n;
    endfunction

    function automatic logic [11:0] mexp(mdl_t m);
        logic [2:0] oh, ena, rstn;
        logic       bsy;
        oh   = 3'(1 << m.lay);
        ena  = (m.ph == P_CLR || m.ph == P_RUN) ? oh : 3'b000;
        rstn = (m.ph == P_CLR) ? ~oh : 3'b111;
        bsy  = (m.ph == P_CLR || m.ph == P_RUN || m.ph == P_GAP);
        return {ena, rstn, 2'(m.lay), bsy, m.dn, m.ov, m.er};
    endfunction

    task automatic chk(string nm, logic [11:0] act, logic [11:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h required=%h", nm, act, exp);
        end
    endtask

    task automatic cyc(bit s, bit a, logic [2:0] d, logic [2:0] o);
        start = s; abort = a; ldone = d; lovf = o;
        @(posedge clk);
        #1;
        m_l = mstep(m_l, s, a, d, o, 20000);
        m_s = mstep(m_s, s, a, d, o, 50);
        chk("model_long", act_l, mexp(m_l));
        chk("model_short", act_s, mexp(m_s));
    endtask

    task automatic arst();
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        chk("arst_long", act_l, 12'b000_111_00_0000);
        chk("arst_short", act_s, 12'b000_111_00_0000);
        m_l = mreset();
        m_s = mreset();
        #2 rst_n = 1'b1;
    endtask

    typedef struct packed {
        logic        s;
        logic        a;
        logic [2:0]  d;
        logic [2:0]  o;
        logic [11:0] exp;
    } vec_t;

    function automatic vec_t mk(bit s, bit a, bit [2:0] d, bit [2:0] o,
                                bit [2:0] ena, bit [2:0] rstn, bit [1:0] sl,
                                bit bsy, bit dn, bit ov, bit er);
        return {s, a, d, o, ena, rstn, sl, bsy, dn, ov, er};
    endfunction

    vec_t tbl[$];

    initial begin
        rst_n = 1'b0; start = 0; abort = 0; ldone = '0; lovf = '0;
        m_l = mreset();
        m_s = mreset();
        repeat (3) @(posedge clk);
        #1;
        chk("reset_long", act_l, 12'b000_111_00_0000);
        chk("reset_short", act_s, 12'b000_111_00_0000);
        @(negedge clk);
        rst_n = 1'b1;

        // full run with stray/ignored inputs, overflow, abort/start mixes
        tbl.push_back(mk(1,0,3'b000,3'b000, 3'b001,3'b110,0, 1,0,0,0));
        tbl.push_back(mk(0,0,3'b111,3'b111, 3'b001,3'b110,0, 1,0,0,0));
        tbl.push_back(mk(0,0,3'b000,3'b000, 3'b001,3'b111,0, 1,0,0,0));
        tbl.push_back(mk(0,0,3'b100,3'b100, 3'b001,3'b111,0, 1,0,0,0));
        tbl.push_back(mk(1,0,3'b000,3'b000, 3'b001,3'b111,0, 1,0,0,0));
        tbl.push_back(mk(0,0,3'b001,3'b000, 3'b000,3'b111,0, 1,0,0,0));
        tbl.push_back(mk(0,0,3'b000,3'b000, 3'b010,3'b101,1, 1,0,0,0));
        tbl.push_back(mk(0,0,3'b000,3'b000, 3'b010,3'b101,1, 1,0,0,0));
        tbl.push_back(mk(0,0,3'b000,3'b000, 3'b010,3'b111,1, 1,0,0,0));
        tbl.push_back(mk(0,0,3'b010,3'b010, 3'b000,3'b111,1, 1,0,1,0));
        tbl.push_back(mk(0,0,3'b000,3'b000, 3'b100,3'b011,2, 1,0,1,0));
        tbl.push_back(mk(0,0,3'b000,3'b000, 3'b100,3'b011,2, 1,0,1,0));
        tbl.push_back(mk(0,0,3'b000,3'b000, 3'b100,3'b111,2, 1,0,1,0));
        tbl.push_back(mk(0,0,3'b100,3'b000, 3'b000,3'b111,2, 0,1,1,0));
        tbl.push_back(mk(1,1,3'b000,3'b000, 3'b000,3'b111,2, 0,1,1,0));
        tbl.push_back(mk(0,0,3'b000,3'b000, 3'b000,3'b111,2, 0,1,1,0));
        tbl.push_back(mk(1,0,3'b000,3'b000, 3'b001,3'b110,0, 1,0,0,0));
        tbl.push_back(mk(0,0,3'b000,3'b000, 3'b001,3'b110,0, 1,0,0,0));
        tbl.push_back(mk(0,0,3'b000,3'b000, 3'b001,3'b111,0, 1,0,0,0));
        tbl.push_back(mk(0,0,3'b001,3'b000, 3'b000,3'b111,0, 1,0,0,0));
        tbl.push_back(mk(0,0,3'b000,3'b000, 3'b010,3'b101,1, 1,0,0,0));
        tbl.push_back(mk(0,0,3'b000,3'b000, 3'b010,3'b101,1, 1,0,0,0));
        tbl.push_back(mk(0,0,3'b000,3'b000, 3'b010,3'b111,1, 1,0,0,0));
        tbl.push_back(mk(0,1,3'b000,3'b000, 3'b000,3'b111,1, 0,0,0,0));
        tbl.push_back(mk(1,0,3'b000,3'b000, 3'b001,3'b110,0, 1,0,0,0));
        tbl.push_back(mk(0,1,3'b000,3'b000, 3'b000,3'b111,0, 0,0,0,0));

        foreach (tbl[i]) begin
            cyc(tbl[i].s, tbl[i].a, tbl[i].d, tbl[i].o);
            chk($sformatf("vec%0d", i), act_l, tbl[i].exp);
        end

        // each engine done in its 100th RUN cycle; short watchdog trips
        cyc(1, 0, 3'b000, 3'b000);
        for (int L = 0; L < 3; L++) begin
            cyc(0, 0, 3'b000, 3'b000);
            cyc(0, 0, 3'b000, 3'b000);
            for (int k = 2; k <= 100; k++) begin
                cyc(0, 0, 3'b000, 3'b000);
                if (L == 0 && k == 50)
                    chk("wd_pre", 12'({busy_s, err_s}), 12'b10);
                if (L == 0 && k == 51)
                    chk("wd_err", 12'({ena_s, sel_s, busy_s, err_s}),
                        12'b000_00_0_1);
            end
            cyc(0, 0, 3'(1 << L), 3'b000);
            if (L < 2) begin
                chk("gap_zero", 12'({ena_l, busy_l}), 12'b000_1);
                cyc(0, 0, 3'b000, 3'b000);
            end
        end
        chk("run_final", 12'({ena_l, busy_l, done_l, ovf_l, err_l}),
            12'b000_0_1_0_0);

        // done arrives in the very cycle the short watchdog would expire
        cyc(1, 0, 3'b000, 3'b000);
        cyc(0, 0, 3'b000, 3'b000);
        cyc(0, 0, 3'b000, 3'b000);
        for (int k = 2; k <= 50; k++) cyc(0, 0, 3'b000, 3'b000);
        cyc(0, 0, 3'b001, 3'b000);
        chk("wd_tie", 12'({ena_s, sel_s, busy_s, err_s}), 12'b000_00_1_0);
        cyc(0, 1, 3'b000, 3'b000);

        // asynchronous reset in the middle of RUN
        cyc(1, 0, 3'b000, 3'b000);
        repeat (5) cyc(0, 0, 3'b000, 3'b000);
        arst();
        cyc(1, 0, 3'b000, 3'b000);
        chk("post_arst", 12'({ena_l, sel_l, busy_l}), 12'b001_00_1);

        // random traffic
        for (int n = 0; n < 4000; n++) begin
            logic [2:0] d;
            d[0] = ($urandom % 20) == 0;
            d[1] = ($urandom % 20) == 0;
            d[2] = ($urandom % 20) == 0;
            cyc(($urandom % 8) == 0, ($urandom % 60) == 0, d,
                3'($urandom % 8));
            if (($urandom % 700) == 0) arst();
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/tpu_layer_sequencer.md
TPU_LAYER_SEQUENCER -- requirements
Module: tpu_layer_sequencer

Interface
REQ-001 SHALL have parameter NUM_LAYERS, default 3, number of layer engines sequenced (1..4).
REQ-002 SHALL have parameter TIMEOUT_CYCLES, default 16'd20000, per-layer watchdog limit in clk cycles.
REQ-003 SHALL have port clk  input  1  single clock; all state updates on rising edge.
REQ-004 SHALL have port iRst_n  input  1  reset, asynchronous, active-low.
REQ-005 SHALL have port start  input  1  request to run all layers in order; level sampled each cycle.
REQ-006 SHALL have port abort  input  1  stop current run and return to IDLE.
REQ-007 SHALL have port layer_done  input  NUM_LAYERS  per-engine done flag.
REQ-008 SHALL have port layer_overflow  input  NUM_LAYERS  per-engine overflow flag.
REQ-009 SHALL have port layer_ena  output  NUM_LAYERS  one-hot engine enable; all-zero when no engine is selected.
REQ-010 SHALL have port layer_rst_n  output  NUM_LAYERS  per-engine synchronous reset, active-low.
REQ-011 SHALL have port sel  output  2  index of the engine that owns ROM, RAM and MultAdder ports.
REQ-012 SHALL have port busy, done, overflow, error  output  1 each  run status flags.

Function
REQ-013 SHALL implement the states IDLE, CLEAR, RUN, GAP, FIN and ERR.
REQ-014 IDLE: SHALL drive layer_ena=0 and layer_rst_n=all-ones; start=1 with abort=0 -> CLEAR, sel=0, overflow cleared, done cleared, error cleared.
REQ-015 CLEAR: SHALL last exactly 2 cycles with layer_ena[sel]=1 and layer_rst_n[sel]=0, all other bits of layer_rst_n=1, then go to RUN.
REQ-016 RUN: SHALL drive layer_ena[sel]=1 and layer_rst_n=all-ones; SHALL increment a 16-bit watchdog counter that is cleared on entry to RUN.
REQ-017 RUN with layer_done[sel]=1: SHALL set overflow to overflow OR layer_overflow[sel] in the same edge; then go to FIN if sel==NUM_LAYERS-1, otherwise go to GAP.
REQ-018 GAP: SHALL drive layer_ena=0 for exactly 1 cycle, increment sel by 1, then go to CLEAR.
REQ-019 FIN: SHALL hold done=1 and layer_ena=0; start=1 -> CLEAR, beginning a new run with the same clearing as REQ-014.
REQ-020 Watchdog: SHALL go RUN -> ERR when the counter equals TIMEOUT_CYCLES-1 and layer_done[sel]=0; ERR SHALL hold error=1 and layer_ena=0; start=1 -> CLEAR as in REQ-014.
REQ-021 When layer_done[sel] rises on the same cycle the watchdog expires, done SHALL take priority and no error SHALL be raised.
REQ-022 abort=1 in any state SHALL put the block in IDLE on the next edge, with layer_ena=0 and done, error and overflow preserved; abort SHALL have priority over start.
REQ-023 start SHALL be ignored in CLEAR, RUN and GAP.
REQ-024 layer_done and layer_overflow bits of non-selected engines SHALL be ignored; layer_done SHALL be ignored in CLEAR.
REQ-025 busy SHALL be 1 exactly in CLEAR, RUN and GAP; sel SHALL hold its value in FIN, ERR and IDLE.
REQ-026 All outputs SHALL be registered, with no combinational path from input to output.

Reset
REQ-027 While iRst_n=0, the block SHALL be in IDLE with sel=0, watchdog=0, layer_ena=0, layer_rst_n=all-ones, busy=0, done=0, overflow=0, error=0.
REQ-028 Reset asserted mid-run SHALL force the REQ-027 values immediately, without waiting for clk; the first edge after release SHALL evaluate the IDLE transitions.

Verification
REQ-029 Normal run: pulse start, each engine raises done 100 cycles after its CLEAR ends -> layer_ena sequence 001,010,100 with 1-cycle zero gaps, done=1, overflow=0, busy=0.
REQ-030 Overflow: layer_overflow[1]=1 together with layer_done[1] -> final overflow=1, done=1.
REQ-031 Timeout: TIMEOUT_CYCLES=50, engine 0 never done -> ERR after 50 RUN cycles, error=1, layer_ena=000, sel=0.
REQ-032 Abort: abort during RUN of engine 1 -> next cycle IDLE, layer_ena=000, busy=0, done=0; start afterwards -> CLEAR with sel=0.
REQ-033 Corner cases: layer_done[sel] on the watchdog-expiry cycle -> no error; start and abort together -> IDLE; stray layer_done[2] while sel=0 -> no effect.
REQ-034 Async reset: iRst_n low between edges during RUN -> layer_ena=000 and busy=0 before the next clk edge.
